// File: rtl/lga_pkg.sv
// Shared constants for the logic unit arbiter: opcodes, FSM encoding, widths.
package lga_pkg;

  localparam int OP_W = 3;
  localparam int ID_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the requesters and the logic unit arbiter.
// Optional macro LGA_ILLEGAL_OP_CHECK_EN adds the o_rsp_err signal.
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        i_req_valid;
  logic [3*NUM_REQ-1:0]      i_req_op;
  logic [DATA_W*NUM_REQ-1:0] i_req_a;
  logic [DATA_W*NUM_REQ-1:0] i_req_b;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic                      o_rsp_valid;
  logic [2:0]                o_rsp_id;
  logic [DATA_W-1:0]         o_rsp_y;
  logic                      i_rsp_ready;
`ifdef LGA_ILLEGAL_OP_CHECK_EN
  logic                      o_rsp_err;
`endif

  // Requester / consumer side
  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
`ifdef LGA_ILLEGAL_OP_CHECK_EN
    input  o_rsp_err,
`endif
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_y
  );

  // Arbiter side
  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
`ifdef LGA_ILLEGAL_OP_CHECK_EN
    output o_rsp_err,
`endif
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_y
  );

endinterface

// File: rtl/lga_rr_arbiter.sv
// Combinational round-robin picker: first valid index scanning upward from
// pointer+1 (wrapping at NUM_REQ). Produces a one-hot grant and its index.
module lga_rr_arbiter
  import lga_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [7:0]         valid_ext_s;
  logic [3:0]         sum_s;
  logic [ID_W-1:0]    idx_s;
  logic               found_s;
  logic [NUM_REQ-1:0] grant_s;

  // Scan candidates in priority order and keep the first valid one
  always_comb begin
    valid_ext_s = 8'(i_valid);
    sum_s       = 4'd0;
    idx_s       = 3'd0;
    found_s     = 1'b0;
    grant_s     = {NUM_REQ{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s = {1'b0, i_ptr} + 4'(i);
      if (sum_s >= 4'(NUM_REQ)) begin
        sum_s = sum_s - 4'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && valid_ext_s[sum_s[2:0]]) begin
        found_s = 1'b1;
        idx_s   = sum_s[2:0];
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_s[k] = found_s && (idx_s == 3'(k));
    end
  end

  assign o_grant = grant_s;
  assign o_idx   = idx_s;
  assign o_any   = found_s;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic function unit between NUM_REQ requesters.
// Round-robin grant in IDLE, one compute cycle in EXEC, result held in RESP
// until the consumer takes it. Optional macro LGA_ILLEGAL_OP_CHECK_EN flags
// the reserved opcode on o_rsp_err.
module logic_unit_arbiter
  import lga_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  logic_unit_arbiter_if.slave   bus
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_y_q, rsp_y_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
`ifdef LGA_ILLEGAL_OP_CHECK_EN
  logic               rsp_err_q, rsp_err_d;
`endif

  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    win_idx_s;
  logic               any_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [OP_W-1:0]    sel_op_s;
  logic [DATA_W-1:0]  sel_a_s;
  logic [DATA_W-1:0]  sel_b_s;
  logic [DATA_W-1:0]  fu_y_s;

  lga_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_valid (bus.i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant_s),
    .o_idx   (win_idx_s),
    .o_any   (any_s)
  );

  // Route the winning requester's opcode and operands (grant is one-hot)
  always_comb begin
    sel_op_s = {OP_W{1'b0}};
    sel_a_s  = {DATA_W{1'b0}};
    sel_b_s  = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_s[k]) begin
        sel_op_s = bus.i_req_op[k*OP_W +: OP_W];
        sel_a_s  = bus.i_req_a[k*DATA_W +: DATA_W];
        sel_b_s  = bus.i_req_b[k*DATA_W +: DATA_W];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // Shared bitwise function unit on the latched operands
  always_comb begin
    fu_y_s = {DATA_W{1'b0}};
    case (op_q)
      OP_NOT:  fu_y_s = ~a_q;
      OP_AND:  fu_y_s = a_q & b_q;
      OP_OR:   fu_y_s = a_q | b_q;
      OP_NAND: fu_y_s = ~(a_q & b_q);
      OP_NOR:  fu_y_s = ~(a_q | b_q);
      OP_XOR:  fu_y_s = a_q ^ b_q;
      OP_XNOR: fu_y_s = ~(a_q ^ b_q);
      default: fu_y_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state and accept strobe for the accept / compute / respond sequence
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
`ifdef LGA_ILLEGAL_OP_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (any_s) begin
          req_ready_s = grant_s;
          op_d        = sel_op_s;
          a_d         = sel_a_s;
          b_d         = sel_b_s;
          id_d        = win_idx_s;
          state_d     = S_EXEC;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_EXEC: begin
        rsp_y_d     = fu_y_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
`ifdef LGA_ILLEGAL_OP_CHECK_EN
        rsp_err_d   = (op_q == OP_RSVD);
`endif
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef LGA_ILLEGAL_OP_CHECK_EN
          rsp_err_d   = 1'b0;
`endif
          // Just-served requester drops to lowest priority
          ptr_d       = id_q;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      op_q        <= {OP_W{1'b0}};
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      id_q        <= {ID_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= {DATA_W{1'b0}};
      rsp_id_q    <= {ID_W{1'b0}};
`ifdef LGA_ILLEGAL_OP_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
`ifdef LGA_ILLEGAL_OP_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.o_req_ready = req_ready_s;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_y     = rsp_y_q;
  assign bus.o_rsp_id    = rsp_id_q;
`ifdef LGA_ILLEGAL_OP_CHECK_EN
  assign bus.o_rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: a monitor pushes expected
// results when a grant is seen and pops/compares them at each response handshake.
module tb_logic_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  typedef struct {
    int         id;
    logic [7:0] y;
    logic       err;
    int         gcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic       last_valid = 1'b0;
  logic       last_hs    = 1'b0;
  logic [7:0] last_y     = 8'h00;
  logic [2:0] last_id    = 3'd0;
  logic [7:0] sweep_exp [0:6];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic get_err();
`ifdef LGA_ILLEGAL_OP_CHECK_EN
    return bus.o_rsp_err;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      last_valid = 1'b0;
      last_hs    = 1'b0;
    end else begin
      check_val("ready_onehot", 32'($countones(bus.o_req_ready) <= 1), 32'd1);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.o_req_ready[k]) begin
          check_val("ready_needs_valid", bus.i_req_valid[k], 1);
          mon_e.id   = k;
          mon_e.y    = model_y(bus.i_req_op[3*k +: 3], bus.i_req_a[8*k +: 8], bus.i_req_b[8*k +: 8]);
          mon_e.err  = (bus.i_req_op[3*k +: 3] == 3'd7);
          mon_e.gcyc = cyc;
          sb_q.push_back(mon_e);
        end
      end
      if (bus.o_rsp_valid) begin
        check_val("rsp_no_grant", bus.o_req_ready, 0);
        if (last_valid && !last_hs) begin
          check_val("hold_y", bus.o_rsp_y, last_y);
          check_val("hold_id", bus.o_rsp_id, last_id);
        end else if (sb_q.size() == 0) begin
          check_val("spurious_rsp", 1, 0);
        end else begin
          check_val("latency", cyc - sb_q[0].gcyc, 2);
        end
        if (bus.i_rsp_ready && sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_val("sb_y", bus.o_rsp_y, mon_e.y);
          check_val("sb_id", bus.o_rsp_id, mon_e.id);
`ifdef LGA_ILLEGAL_OP_CHECK_EN
          check_val("sb_err", bus.o_rsp_err, mon_e.err);
`endif
        end
      end
      last_valid = bus.o_rsp_valid;
      last_hs    = bus.o_rsp_valid && bus.i_rsp_ready;
      last_y     = bus.o_rsp_y;
      last_id    = bus.o_rsp_id;
    end
  end

  task automatic set_req(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.i_req_valid[k]    = 1'b1;
    bus.i_req_op[3*k +: 3] = op;
    bus.i_req_a[8*k +: 8] = a;
    bus.i_req_b[8*k +: 8] = b;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int t = 0; t < 40 && idx < 0; t++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.o_req_ready[k]) idx = k;
      end
    end
    if (idx < 0) check_val("grant_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output logic [7:0] y, output logic [2:0] id, output logic err);
    bit got = 1'b0;
    y = 8'h00; id = 3'd0; err = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        y = bus.o_rsp_y; id = bus.o_rsp_id; err = get_err(); got = 1'b1;
      end
    end
    if (!got) check_val("rsp_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.i_req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         idx;
    logic [7:0] y;
    logic [2:0] id;
    logic       err;
    bit         seen;

    sweep_exp[0] = 8'h5A; sweep_exp[1] = 8'h24; sweep_exp[2] = 8'hBD; sweep_exp[3] = 8'hDB;
    sweep_exp[4] = 8'h42; sweep_exp[5] = 8'h99; sweep_exp[6] = 8'h66;
    bus.i_req_valid = '0;
    bus.i_req_op    = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 1'b1;
    reset_dut();

    // Reset / idle
    repeat (10) begin
      @(negedge clk);
      check_val("idle_ready", bus.o_req_ready, 0);
      check_val("idle_valid", bus.o_rsp_valid, 0);
      check_val("idle_y", bus.o_rsp_y, 0);
      check_val("idle_id", bus.o_rsp_id, 0);
    end
    @(posedge clk); #1;

    // Single-op sweep on requester 2
    for (int op = 0; op < 7; op++) begin
      set_req(2, 3'(op), 8'hA5, 8'h3C);
      wait_grant(idx);
      check_val("sweep_grant", idx, 2);
      bus.i_req_valid[2] = 1'b0;
      wait_rsp(y, id, err);
      check_val("sweep_y", y, sweep_exp[op]);
      check_val("sweep_id", id, 2);
    end

    // Round-robin with all requesters valid
    reset_dut();
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 3'd1, 8'(8'h11 * k), 8'hF0);
    for (int i = 0; i < 6; i++) begin
      wait_grant(idx);
      check_val("rr_order", idx, i % 4);
    end
    bus.i_req_valid = '0;
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: requesters 0 and 3 waiting, pointer at 1 -> 3 first
    bus.i_rsp_ready = 1'b0;
    set_req(0, 3'd5, 8'h0F, 8'hFF);
    set_req(3, 3'd2, 8'h81, 8'h18);
    wait_grant(idx);
    check_val("bp_first", idx, 3);
    bus.i_req_valid[3] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = bus.o_rsp_valid;
    end
    check_val("bp_valid_seen", seen, 1);
    repeat (5) begin
      @(negedge clk);
      check_val("bp_valid_held", bus.o_rsp_valid, 1);
      check_val("bp_no_ready", bus.o_req_ready, 0);
      check_val("bp_y", bus.o_rsp_y, 8'h99);
    end
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    check_val("bp_hs_valid", bus.o_rsp_valid, 1);
    @(negedge clk);
    check_val("bp_next_grant", bus.o_req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.i_req_valid[0] = 1'b0;
    wait_rsp(y, id, err);
    check_val("bp_second_id", id, 0);

    // Reset during EXEC for requester 1
    set_req(1, 3'd1, 8'hFF, 8'hAA);
    wait_grant(idx);
    check_val("mid_grant", idx, 1);
    rst = 1'b1;
    bus.i_req_valid[1] = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_val("mid_rst_valid", bus.o_rsp_valid, 0);
    check_val("mid_rst_ready", bus.o_req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_val("mid_no_rsp", bus.o_rsp_valid, 0);
    end
    @(posedge clk); #1;
    set_req(0, 3'd4, 8'h10, 8'h01);
    set_req(2, 3'd6, 8'h33, 8'h0F);
    wait_grant(idx);
    check_val("post_rst_first", idx, 0);
    bus.i_req_valid[0] = 1'b0;
    wait_rsp(y, id, err);
    check_val("post_rst_y", y, 8'hEE);
    wait_grant(idx);
    check_val("post_rst_second", idx, 2);
    bus.i_req_valid[2] = 1'b0;
    wait_rsp(y, id, err);
    check_val("post_rst_y2", y, 8'hC3);

    // Reserved opcode then a legal one
    set_req(3, 3'd7, 8'hFF, 8'hFF);
    wait_grant(idx);
    bus.i_req_valid[3] = 1'b0;
    wait_rsp(y, id, err);
    check_val("op7_y", y, 8'h00);
    check_val("op7_id", id, 3);
`ifdef LGA_ILLEGAL_OP_CHECK_EN
    check_val("op7_err", err, 1);
`endif
    set_req(3, 3'd1, 8'hFF, 8'h0F);
    wait_grant(idx);
    bus.i_req_valid[3] = 1'b0;
    wait_rsp(y, id, err);
    check_val("legal_y", y, 8'h0F);
`ifdef LGA_ILLEGAL_OP_CHECK_EN
    check_val("legal_err", err, 0);
`endif

    repeat (3) @(negedge clk);
    check_val("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
